// File: rtl/ss_pkg.sv
// Shared definitions for the save-state bus master: FSM encoding, header word
// layout and the width of the slave acknowledge timer.
package ss_pkg;

  typedef enum logic [3:0] {
    IDLE,
    QUERY,
    HDR,
    SLV_RD,
    MEM_WR,
    MEM_RD,
    SLV_WR,
    NEXT,
    TRAILER,
    FINISH,
    FAULT
  } state_t;

  // Header word: {index[7:0], 24'd0, count[31:0]}
  localparam int HDR_IDX_LSB = 56;
  localparam int HDR_IDX_W   = 8;
  localparam int HDR_CNT_LSB = 0;
  localparam int HDR_CNT_W   = 32;

  localparam int ACK_TO_W = 16;

  function automatic logic [63:0] make_hdr(input logic [7:0] idx, input logic [31:0] cnt);
    return {idx, 24'd0, cnt};
  endfunction

endpackage

// File: rtl/ssbus_if.sv
// Save-state bus: one master selects a slave index and queries, reads or
// writes it; the slave answers with ack and, for query/read, data_out.
interface ssbus_if;
  logic [7:0]  select;
  logic [23:0] addr;
  logic [63:0] data;
  logic        query;
  logic        read;
  logic        write;
  logic [63:0] data_out;
  logic        ack;

  modport master (
    output select, addr, data, query, read, write,
    input  data_out, ack
  );

  modport slave (
    input  select, addr, data, query, read, write,
    output data_out, ack
  );
endinterface

// File: rtl/ssbus_mem_req.sv
// Single outstanding memory request: a start pulse latches address and data,
// which stay stable until the cycle mem_ready is seen with the request high.
module ssbus_mem_req (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_rd,
  input  logic        start_wr,
  input  logic [31:0] addr,
  input  logic [63:0] wdata,
  output logic [31:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic        mem_read,
  output logic        mem_write,
  input  logic        mem_ready,
  output logic        busy,
  output logic        complete
);

  logic [31:0] addr_reg;
  logic [63:0] wdata_reg;
  logic        read_reg;
  logic        write_reg;

  assign busy     = read_reg || write_reg;
  assign complete = busy && mem_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_reg  <= '0;
      wdata_reg <= '0;
      read_reg  <= 1'b0;
      write_reg <= 1'b0;
    end else if (complete) begin
      read_reg  <= 1'b0;
      write_reg <= 1'b0;
    end else if (!busy && (start_rd || start_wr)) begin
      addr_reg  <= addr;
      wdata_reg <= wdata;
      read_reg  <= start_rd;
      write_reg <= start_wr && !start_rd;
    end
  end

  assign mem_addr  = addr_reg;
  assign mem_wdata = wdata_reg;
  assign mem_read  = read_reg;
  assign mem_write = write_reg;

endmodule

// File: rtl/ssbus_master.sv
// Walks save-state slaves 0..NUM_SLAVES-1, streaming their state to or from a
// memory image. Define SSBUS_CHECKSUM_EN to add an XOR checksum trailer word.
module ssbus_master
  import ss_pkg::*;
#(
  parameter int NUM_SLAVES  = 32,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        save_start,
  input  logic        restore_start,
  input  logic [31:0] base_addr,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [31:0] mem_addr,
  output logic [63:0] mem_wdata,
  input  logic [63:0] mem_rdata,
  output logic        mem_read,
  output logic        mem_write,
  input  logic        mem_ready,
  ssbus_if.master     ssb
);

  state_t               state_reg, state_next;
  logic                 save_mode_reg;
  logic                 error_reg;
  logic [31:0]          addr_reg, addr_next;
  logic [7:0]           index_reg, index_next;
  logic [31:0]          count_reg, count_next;
  logic [31:0]          word_reg, word_next;
  logic [63:0]          data_reg, data_next;
  logic [ACK_TO_W-1:0]  timer_reg;
`ifdef SSBUS_CHECKSUM_EN
  logic [63:0]          csum_reg, csum_next;
`endif

  logic        start_accept;
  logic        ack_wait;
  logic        ack_timeout;
  logic        mem_start_rd;
  logic        mem_start_wr;
  logic        mem_busy;
  logic        mem_done;
  logic [63:0] mem_wdata_sel;

  assign start_accept = (state_reg == IDLE) && (save_start || restore_start);
  assign ack_wait     = (state_reg == QUERY) || (state_reg == SLV_RD) || (state_reg == SLV_WR);
  assign ack_timeout  = ack_wait && !ssb.ack && (timer_reg == ACK_TO_W'(ACK_TIMEOUT - 1));

  always_comb begin
    state_next    = state_reg;
    addr_next     = addr_reg;
    index_next    = index_reg;
    count_next    = count_reg;
    word_next     = word_reg;
    data_next     = data_reg;
`ifdef SSBUS_CHECKSUM_EN
    csum_next     = csum_reg;
`endif
    mem_start_rd  = 1'b0;
    mem_start_wr  = 1'b0;
    mem_wdata_sel = data_reg;

    case (state_reg)
      IDLE: begin
        if (start_accept) begin
          state_next = QUERY;
          addr_next  = base_addr;
          index_next = '0;
`ifdef SSBUS_CHECKSUM_EN
          csum_next  = '0;
`endif
        end
      end
      QUERY: begin
        // An absent slave (no ack) is treated as having nothing to save.
        if (ssb.ack || ack_timeout) begin
          count_next = ssb.ack ? ssb.data_out[31:0] : 32'd0;
          word_next  = '0;
          state_next = HDR;
        end
      end
      HDR: begin
        mem_wdata_sel = make_hdr(index_reg, count_reg);
        mem_start_wr  = save_mode_reg && !mem_busy;
        mem_start_rd  = !save_mode_reg && !mem_busy;
        if (mem_done) begin
          addr_next = addr_reg + 32'd8;
          if (!save_mode_reg &&
              ((mem_rdata[HDR_IDX_LSB +: HDR_IDX_W] != index_reg) ||
               (mem_rdata[HDR_CNT_LSB +: HDR_CNT_W] != count_reg)))
            state_next = FAULT;
          else if (count_reg == 32'd0)
            state_next = NEXT;
          else
            state_next = save_mode_reg ? SLV_RD : MEM_RD;
        end
      end
      SLV_RD: begin
        if (ssb.ack) begin
          data_next  = ssb.data_out;
`ifdef SSBUS_CHECKSUM_EN
          csum_next  = csum_reg ^ ssb.data_out;
`endif
          state_next = MEM_WR;
        end else if (ack_timeout) begin
          state_next = FAULT;
        end
      end
      MEM_WR: begin
        mem_start_wr = !mem_busy;
        if (mem_done) begin
          addr_next  = addr_reg + 32'd8;
          word_next  = word_reg + 32'd1;
          state_next = (word_reg + 32'd1 == count_reg) ? NEXT : SLV_RD;
        end
      end
      MEM_RD: begin
        mem_start_rd = !mem_busy;
        if (mem_done) begin
          addr_next  = addr_reg + 32'd8;
          data_next  = mem_rdata;
`ifdef SSBUS_CHECKSUM_EN
          csum_next  = csum_reg ^ mem_rdata;
`endif
          state_next = SLV_WR;
        end
      end
      SLV_WR: begin
        if (ssb.ack) begin
          word_next  = word_reg + 32'd1;
          state_next = (word_reg + 32'd1 == count_reg) ? NEXT : MEM_RD;
        end else if (ack_timeout) begin
          state_next = FAULT;
        end
      end
      NEXT: begin
        if (index_reg == 8'(NUM_SLAVES - 1)) begin
          state_next = TRAILER;
        end else begin
          index_next = index_reg + 8'd1;
          state_next = QUERY;
        end
      end
      TRAILER: begin
`ifdef SSBUS_CHECKSUM_EN
        mem_wdata_sel = csum_reg;
        mem_start_wr  = save_mode_reg && !mem_busy;
        mem_start_rd  = !save_mode_reg && !mem_busy;
        if (mem_done) begin
          addr_next  = addr_reg + 32'd8;
          state_next = (!save_mode_reg && (mem_rdata != csum_reg)) ? FAULT : FINISH;
        end
`else
        state_next = FINISH;
`endif
      end
      FINISH:  state_next = IDLE;
      FAULT:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      save_mode_reg <= 1'b0;
      error_reg     <= 1'b0;
      addr_reg      <= '0;
      index_reg     <= '0;
      count_reg     <= '0;
      word_reg      <= '0;
      data_reg      <= '0;
      timer_reg     <= '0;
`ifdef SSBUS_CHECKSUM_EN
      csum_reg      <= '0;
`endif
    end else begin
      state_reg <= state_next;
      addr_reg  <= addr_next;
      index_reg <= index_next;
      count_reg <= count_next;
      word_reg  <= word_next;
      data_reg  <= data_next;
`ifdef SSBUS_CHECKSUM_EN
      csum_reg  <= csum_next;
`endif
      if (start_accept) begin
        save_mode_reg <= save_start;
        error_reg     <= 1'b0;
      end else if (state_next == FAULT) begin
        error_reg <= 1'b1;
      end
      // Restarts from zero on every new ack wait.
      timer_reg <= (ack_wait && !ssb.ack && (state_next == state_reg)) ?
                   timer_reg + 1'b1 : '0;
    end
  end

  ssbus_mem_req u_mem_req (
    .clk       (clk),
    .reset     (reset),
    .start_rd  (mem_start_rd),
    .start_wr  (mem_start_wr),
    .addr      (addr_reg),
    .wdata     (mem_wdata_sel),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_ready (mem_ready),
    .busy      (mem_busy),
    .complete  (mem_done)
  );

  assign busy  = (state_reg != IDLE);
  assign done  = (state_reg == FINISH) || (state_reg == FAULT);
  assign error = error_reg;

  assign ssb.query  = (state_reg == QUERY);
  assign ssb.read   = (state_reg == SLV_RD);
  assign ssb.write  = (state_reg == SLV_WR);
  assign ssb.select = index_reg;
  assign ssb.addr   = word_reg[23:0];
  assign ssb.data   = data_reg;

endmodule

// File: tb/tb_ssbus_master.sv
// Scoreboard bench for ssbus_master with two save-state slaves; memory and
// slave models check each observed transfer against queued expectations.
module tb_ssbus_master;
  localparam int NS = 2;
  localparam logic [63:0] D0   = 64'h1111_2222_3333_4444;
  localparam logic [63:0] D1   = 64'hA5A5_0000_FFFF_0001;
  localparam logic [63:0] D2   = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] HDR0 = 64'h0000_0000_0000_0003;
  localparam logic [63:0] HDR1 = 64'h0100_0000_0000_0000;
  localparam logic [63:0] CSUM = 64'hB597_6745_4567_89AA;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        save_start = 1'b0;
  logic        restore_start = 1'b0;
  logic [31:0] base_addr = 32'h0000_1000;
  logic        busy, done, error;
  logic [31:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata = '0;
  logic        mem_read, mem_write;
  logic        mem_ready = 1'b0;

  ssbus_if ssb_bus ();

  ssbus_master #(.NUM_SLAVES(NS), .ACK_TIMEOUT(255)) dut (
    .clk           (clk),
    .reset         (reset),
    .save_start    (save_start),
    .restore_start (restore_start),
    .base_addr     (base_addr),
    .busy          (busy),
    .done          (done),
    .error         (error),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_ready     (mem_ready),
    .ssb           (ssb_bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end else begin
      $display("ok   %s = %h", name, act);
    end
  endtask

  typedef struct { logic [31:0] addr; logic [63:0] data; } mem_exp_t;
  typedef struct { logic [7:0] sel; logic [23:0] addr; logic [63:0] data; } slv_exp_t;
  mem_exp_t exp_mem_q[$];
  slv_exp_t exp_slv_q[$];
  mem_exp_t mexp;
  slv_exp_t sexp;

  // Memory model: one-cycle ready, optional stall address and read corruption.
  logic [63:0] mem_model [logic [31:0]];
  logic [31:0] stall_addr   = 32'hFFFF_FFFF;
  logic [31:0] corrupt_addr = 32'hFFFF_FFFF;
  logic [63:0] corrupt_mask = '0;
  logic [63:0] rd_word;

  always @(negedge clk) begin
    if (!mem_ready && (mem_read || mem_write) && (mem_addr != stall_addr)) begin
      mem_ready = 1'b1;
      if (mem_write) begin
        mem_model[mem_addr] = mem_wdata;
        $display("mem write addr=%h data=%h", mem_addr, mem_wdata);
        if (exp_mem_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL mem_wr_unexpected actual addr=%h data=%h required=no write", mem_addr, mem_wdata);
        end else begin
          mexp = exp_mem_q.pop_front();
          chk("mem_wr_addr", {32'h0, mem_addr}, {32'h0, mexp.addr});
          chk("mem_wr_data", mem_wdata, mexp.data);
        end
      end else begin
        rd_word   = mem_model.exists(mem_addr) ? mem_model[mem_addr] : 64'h0;
        mem_rdata = rd_word ^ ((mem_addr == corrupt_addr) ? corrupt_mask : 64'h0);
        $display("mem read  addr=%h data=%h", mem_addr, mem_rdata);
      end
    end else begin
      mem_ready = 1'b0;
    end
  end

  // Slave model: acks query/read/write one cycle after it appears.
  logic [31:0] slv_count [NS];
  logic [63:0] slv_data [NS][4];
  logic        read_noack = 1'b0;

  always @(negedge clk) begin
    if (!ssb_bus.ack &&
        (ssb_bus.query || (ssb_bus.read && !read_noack) || ssb_bus.write)) begin
      chk("ssb_one_request", 64'($countones({ssb_bus.query, ssb_bus.read, ssb_bus.write})), 64'd1);
      ssb_bus.ack = 1'b1;
      if (ssb_bus.query) begin
        ssb_bus.data_out = {32'h0, slv_count[ssb_bus.select[0]]};
        $display("slv query sel=%0d", ssb_bus.select);
      end else if (ssb_bus.read) begin
        ssb_bus.data_out = slv_data[ssb_bus.select[0]][ssb_bus.addr[1:0]];
        $display("slv read  sel=%0d addr=%0d", ssb_bus.select, ssb_bus.addr);
      end else begin
        $display("slv write sel=%0d addr=%0d data=%h", ssb_bus.select, ssb_bus.addr, ssb_bus.data);
        if (exp_slv_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL slv_wr_unexpected actual sel=%0d addr=%0d required=no write", ssb_bus.select, ssb_bus.addr);
        end else begin
          sexp = exp_slv_q.pop_front();
          chk("slv_wr_target", {32'h0, ssb_bus.select, ssb_bus.addr}, {32'h0, sexp.sel, sexp.addr});
          chk("slv_wr_data", ssb_bus.data, sexp.data);
        end
      end
    end else begin
      ssb_bus.ack = 1'b0;
    end
  end

  task automatic start(input bit s, input bit r);
    @(negedge clk);
    save_start    = s;
    restore_start = r;
    @(negedge clk);
    save_start    = 1'b0;
    restore_start = 1'b0;
    chk("busy_after_start", {63'h0, busy}, 64'd1);
  endtask

  task automatic wait_done(input int budget, output int cyc, output logic err);
    cyc = 0;
    err = 1'b0;
    while (!done && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL done_timeout waited=%0d required done within %0d", cyc, budget);
    end else begin
      err = error;
      @(negedge clk);
      chk("done_one_cycle", {63'h0, done}, 64'd0);
      chk("busy_after_done", {63'h0, busy}, 64'd0);
    end
  endtask

  task automatic push_mem(input logic [31:0] a, input logic [63:0] d);
    exp_mem_q.push_back('{addr: a, data: d});
  endtask

  task automatic push_save_image();
    push_mem(32'h1000, HDR0);
    push_mem(32'h1008, D0);
    push_mem(32'h1010, D1);
    push_mem(32'h1018, D2);
    push_mem(32'h1020, HDR1);
`ifdef SSBUS_CHECKSUM_EN
    push_mem(32'h1028, CSUM);
`endif
  endtask

  task automatic push_slv(input logic [23:0] a, input logic [63:0] d);
    exp_slv_q.push_back('{sel: 8'd0, addr: a, data: d});
  endtask

  int   cyc;
  logic err;

  initial begin
    slv_count[0] = 32'd3;
    slv_count[1] = 32'd0;
    slv_data[0][0] = D0;
    slv_data[0][1] = D1;
    slv_data[0][2] = D2;
    slv_data[0][3] = '0;
    for (int i = 0; i < 4; i++) slv_data[1][i] = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", {63'h0, busy}, 64'd0);
    chk("rst_done", {63'h0, done}, 64'd0);
    chk("rst_error", {63'h0, error}, 64'd0);
    chk("rst_mem_req", {62'h0, mem_read, mem_write}, 64'd0);
    chk("rst_ssb_req", {61'h0, ssb_bus.query, ssb_bus.read, ssb_bus.write}, 64'd0);
    chk("rst_mem_addr", {32'h0, mem_addr}, 64'd0);
    reset = 1'b0;

    // Save: slave 0 has 3 words, slave 1 has none
    push_save_image();
    start(1'b1, 1'b0);
    wait_done(500, cyc, err);
    chk("save_error", {63'h0, err}, 64'd0);
    chk("save_writes_left", 64'(exp_mem_q.size()), 64'd0);

    // Restore of that image
    push_slv(24'd0, D0);
    push_slv(24'd1, D1);
    push_slv(24'd2, D2);
    start(1'b0, 1'b1);
    wait_done(500, cyc, err);
    chk("restore_error", {63'h0, err}, 64'd0);
    chk("restore_writes_left", 64'(exp_slv_q.size()), 64'd0);

    // Both starts together: save takes priority
    push_save_image();
    start(1'b1, 1'b1);
    wait_done(500, cyc, err);
    chk("both_error", {63'h0, err}, 64'd0);
    chk("both_save_writes_left", 64'(exp_mem_q.size()), 64'd0);

    // Header at slot 0 reads back index 5
    corrupt_addr = 32'h1000;
    corrupt_mask = 64'h0500_0000_0000_0000;
    start(1'b0, 1'b1);
    wait_done(500, cyc, err);
    chk("hdr_mismatch_error", {63'h0, err}, 64'd1);
    chk("error_sticky", {63'h0, error}, 64'd1);
    corrupt_mask = '0;

    // Slave 0 never acks a read
    read_noack = 1'b1;
    push_mem(32'h1000, HDR0);
    start(1'b1, 1'b0);
    wait_done(2000, cyc, err);
    chk("noack_error", {63'h0, err}, 64'd1);
    chk("noack_wait_in_range", {63'h0, (cyc >= 255) && (cyc <= 262)}, 64'd1);
    chk("noack_writes_left", 64'(exp_mem_q.size()), 64'd0);
    read_noack = 1'b0;

    // Reset while the first data write is stalled
    stall_addr = 32'h1008;
    push_mem(32'h1000, HDR0);
    start(1'b1, 1'b0);
    cyc = 0;
    while (!(mem_write && mem_addr == 32'h1008) && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk("stalled_write_seen", {63'h0, mem_write}, 64'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_mid_mem_write", {63'h0, mem_write}, 64'd0);
    chk("rst_mid_busy", {63'h0, busy}, 64'd0);
    chk("rst_mid_mem_addr", {32'h0, mem_addr}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    stall_addr = 32'hFFFF_FFFF;
    repeat (30) @(negedge clk);
    chk("rst_mid_writes_left", 64'(exp_mem_q.size()), 64'd0);
    chk("rst_mid_idle", {62'h0, busy, mem_write}, 64'd0);
    chk("rst_clears_error", {63'h0, error}, 64'd0);

`ifdef SSBUS_CHECKSUM_EN
    // One data word corrupted: all words restored, fault at the trailer
    corrupt_addr = 32'h1010;
    corrupt_mask = 64'h1;
    push_slv(24'd0, D0);
    push_slv(24'd1, D1 ^ 64'h1);
    push_slv(24'd2, D2);
    start(1'b0, 1'b1);
    wait_done(500, cyc, err);
    chk("csum_error", {63'h0, err}, 64'd1);
    chk("csum_writes_left", 64'(exp_slv_q.size()), 64'd0);
    corrupt_mask = '0;
`endif

    chk("final_slv_queue", 64'(exp_slv_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
